// File: rtl/mult_ctrl_n.sv
// Shift-and-add multiplier controller with start/busy/done handshake.
// Define EARLY_EXIT_EN to finish as soon as the multiplier register is zero.
module mult_ctrl_n #(
  parameter int N = 8,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_lsb,
  input  logic             i_zero,
  output logic [15:0]      o_signal,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR  = 4'd1,
    S_TEST = 4'd2,
    S_ADD  = 4'd3,
    S_ADDW = 4'd4,
    S_SHA  = 4'd5,
    S_SHAW = 4'd6,
    S_SHB  = 4'd7,
    S_SHBW = 4'd8,
    S_CHK  = 4'd9,
    S_DONE = 4'd10
  } state_e;

  localparam logic [15:0] W_NOP  = 16'h0000;
  localparam logic [15:0] W_CLR  = 16'h0001;
  localparam logic [15:0] W_TEST = 16'h8200;
  localparam logic [15:0] W_ADD  = 16'h1120;
  localparam logic [15:0] W_ADDW = 16'h1121;
  localparam logic [15:0] W_SHA  = 16'h6200;
  localparam logic [15:0] W_SHAW = 16'h6203;
  localparam logic [15:0] W_SHB  = 16'h2300;
  localparam logic [15:0] W_SHBW = 16'h2305;

  localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exit_now;

`ifdef EARLY_EXIT_EN
  assign exit_now = i_zero || (count_q == CNT_N);
`else
  logic unused_zero;
  assign unused_zero = i_zero;
  assign exit_now    = (count_q == CNT_N);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_CLR;
      S_CLR: begin
        count_d = '0;
        state_d = S_TEST;
      end
      S_TEST: state_d = i_lsb ? S_ADD : S_SHA;
      S_ADD:  state_d = S_ADDW;
      S_ADDW: state_d = S_SHA;
      S_SHA:  state_d = S_SHAW;
      S_SHAW: state_d = S_SHB;
      S_SHB:  state_d = S_SHBW;
      S_SHBW: begin
        count_d = count_q + CNT_ONE;
        state_d = S_CHK;
      end
      S_CHK:  state_d = exit_now ? S_DONE : S_TEST;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register alone.
  always_comb begin
    o_signal = W_NOP;
    o_busy   = 1'b1;
    o_done   = 1'b0;
    unique case (state_q)
      S_IDLE: o_busy   = 1'b0;
      S_CLR:  o_signal = W_CLR;
      S_TEST: o_signal = W_TEST;
      S_ADD:  o_signal = W_ADD;
      S_ADDW: o_signal = W_ADDW;
      S_SHA:  o_signal = W_SHA;
      S_SHAW: o_signal = W_SHAW;
      S_SHB:  o_signal = W_SHB;
      S_SHBW: o_signal = W_SHBW;
      S_CHK:  o_signal = W_NOP;
      S_DONE: o_done   = 1'b1;
      default: o_signal = W_NOP;
    endcase
  end

  assign o_count = count_q;

endmodule

// File: tb/tb_mult_ctrl_n.sv
// Scoreboard bench for mult_ctrl_n with a behavioural datapath model.
module tb_mult_ctrl_n;
  localparam int N = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_lsb;
  logic          i_zero;
  logic [15:0]   o_signal;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_count;

  mult_ctrl_n #(.N(N)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_lsb(i_lsb),
    .i_zero(i_zero), .o_signal(o_signal), .o_busy(o_busy),
    .o_done(o_done), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errs  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // datapath: R0 acc, R1 multiplicand, R2 multiplier
  logic [15:0] r0 = '0, r1 = '0, r2 = '0;
  logic [15:0] ld_a = '0, ld_b = '0;
  logic        ld_en = 1'b0;
  logic [15:0] opa, opb, res;

  function automatic logic [15:0] mux(input logic [3:0] s);
    case (s)
      4'd1: return r0;
      4'd2: return r1;
      4'd3: return r2;
      default: return 16'h0;
    endcase
  endfunction

  always_comb begin
    opa = mux(o_signal[11:8]);
    opb = mux(o_signal[7:4]);
    case (o_signal[15:12])
      4'd1: res = opa + opb;
      4'd2: res = opa >> 1;
      4'd6: res = opa << 1;
      default: res = opa;
    endcase
  end

  assign i_lsb  = r2[0];
  assign i_zero = (r2 == 16'h0);

  always @(posedge clk) begin
    if (ld_en) begin
      r1 <= ld_a;
      r2 <= ld_b;
    end else if (o_signal[0]) begin
      case (o_signal[3:1])
        3'd0: r0 <= res;
        3'd1: r1 <= res;
        3'd2: r2 <= res;
        default: ;
      endcase
    end
  end

  // reference: expected result and timing of each accepted start
  typedef struct {
    logic [15:0] prod;
    int lat;
    int adds;
    int iters;
    int scyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int ready_cyc = 0;

  function automatic int iters_for(input logic [15:0] b);
    int len = 0;
    for (int i = 0; i < N; i++) if (b[i]) len = i + 1;
`ifdef EARLY_EXIT_EN
    return (len < 1) ? 1 : len;
`else
    return N;
`endif
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      ready_cyc = 0;
    end else if (i_start && cyc >= ready_cyc) begin
      e.iters = iters_for(r2);
      e.adds  = 0;
      for (int i = 0; i < e.iters; i++) e.adds += int'(r2[i]);
      e.prod  = 16'((r1 * r2[N-1:0]) & 16'hFFFF);
      e.lat   = 1 + 6 * e.iters + 2 * e.adds;
      e.scyc  = cyc;
      q.push_back(e);
      ready_cyc = cyc + e.lat + 2;
    end
  end

  // monitor
  int done_cnt = 0;
  int adds_seen = 0;
  bit after_done = 1'b0;
  int last_iters = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      adds_seen = 0;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        chk("busy_after_done", 32'(o_busy), 32'd0);
        chk("count_hold_idle", 32'(o_count), 32'(last_iters));
        after_done = 1'b0;
      end
      if (o_signal == 16'h1121) adds_seen++;
      if (o_done) begin
        done_cnt++;
        if (q.size() == 0) begin
          tests++;
          errs++;
          $display("FAIL unexpected_done cyc=%0d exp=none", cyc);
        end else begin
          e = q.pop_front();
          chk("product", 32'(r0), 32'(e.prod));
          chk("latency", 32'(cyc - e.scyc), 32'(e.lat));
          chk("count", 32'(o_count), 32'(e.iters));
          chk("addw_words", 32'(adds_seen), 32'(e.adds));
          last_iters = e.iters;
          after_done = 1'b1;
        end
        adds_seen = 0;
      end
    end
  end

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      tests++;
      errs++;
      $display("FAIL done_timeout act=none exp=done in %0d", budget);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    ld_a  = {8'h0, a};
    ld_b  = {8'h0, b};
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    load(a, b);
    pulse_start();
    wait_done(200);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_signal", 32'(o_signal), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    rst = 1'b0;

    run_op(8'h03, 8'h00);
    run_op(8'h0F, 8'hFF);
    run_op(8'hFF, 8'h01);
    run_op(8'h01, 8'h80);
    for (int i = 0; i < 6; i++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // start pulsed while busy must be ignored
    load(8'h5A, 8'hC3);
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done(200);
    repeat (2) @(negedge clk);

    // start held high: back-to-back operations
    load(8'h07, 8'h81);
    i_start = 1'b1;
    wait_done(200);
    wait_done(200);
    i_start = 1'b0;
    repeat (3) @(negedge clk);

    // reset while in ADD
    load(8'h11, 8'h03);
    pulse_start();
    k = 0;
    while (o_signal != 16'h1120 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("reach_add", 32'(o_signal), 32'h1120);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_signal", 32'(o_signal), 32'h0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", 32'(o_count), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    run_op(8'h11, 8'h03);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
